plate_gate_ctrl: RTL

- Clocked successor to the combinational plate/day validator: a parking-entry gate controller.
- Accepts a plate of N_DIGITS hex digits plus a weekday on a Req handshake, validates plate format, applies weekday parity restriction and capacity limit, then holds the barrier open for a timed window.
- Tracks lot occupancy with an Exit input.
- Sits between the plate reader front-end and the barrier actuator.

---
 rtl/plate_gate_ctrl_pkg.sv | 20 ++
 rtl/plate_format_chk.sv | 39 +++
 rtl/plate_gate_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/plate_gate_ctrl_pkg.sv
// Shared definitions for the parking-entry gate controller:
// digit geometry, deny-code values and the controller state encoding.
package plate_gate_ctrl_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  LETTER_MIN = 4'hA;

  localparam logic [2:0] DENY_NONE     = 3'd0;
  localparam logic [2:0] DENY_PLATE    = 3'd1;
  localparam logic [2:0] DENY_DAY      = 3'd2;
  localparam logic [2:0] DENY_RESTRICT = 3'd3;
  localparam logic [2:0] DENY_FULL     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_OPEN
  } state_t;

endpackage

// File: rtl/plate_format_chk.sv
// Combinational plate format checker.
//   plate    : N_DIGITS hex digits, digit 0 at the MSBs
//   valid    : exactly two letters (>= 0xA), forming an aligned pair (2i, 2i+1)
//   last_num : last digit if numeric, otherwise digit N_DIGITS-3
module plate_format_chk
  import plate_gate_ctrl_pkg::*;
#(
  parameter int unsigned N_DIGITS = 6
) (
  input  logic [DIGIT_W*N_DIGITS-1:0] plate,
  output logic                        valid,
  output logic [DIGIT_W-1:0]          last_num
);

  localparam int unsigned LW = $clog2(N_DIGITS + 1);

  logic [N_DIGITS-1:0] is_letter;
  logic [LW-1:0]       n_letters;
  logic                pair_ok;

  always_comb begin
    is_letter = '0;
    n_letters = '0;
    pair_ok   = 1'b0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      is_letter[j] = (plate[DIGIT_W*(N_DIGITS-1-j) +: DIGIT_W] >= LETTER_MIN);
      if (is_letter[j]) n_letters = n_letters + LW'(1);
    end
    for (int unsigned i = 0; i < N_DIGITS/2; i++) begin
      if (is_letter[2*i] && is_letter[2*i+1]) pair_ok = 1'b1;
    end
  end

  // With exactly two letters, one aligned letter pair implies every other digit is numeric.
  assign valid    = (n_letters == LW'(2)) && pair_ok;
  assign last_num = is_letter[N_DIGITS-1] ? plate[2*DIGIT_W +: DIGIT_W]
                                          : plate[DIGIT_W-1:0];

endmodule

// File: rtl/plate_gate_ctrl.sv
// Parking-entry gate controller.
//   Clk, Reset          : rising-edge clock, synchronous active-high reset
//   Req, Plate, Dia     : request handshake (sampled only when idle), plate, weekday 1..7
//   Exit                : one-cycle pulse per departing vehicle
//   Busy                : controller not idle
//   Done                : one-cycle strobe qualifying MatrVal, Granted, DenyCode
//   Barreira            : barrier open, OPEN_CYCLES cycles per grant
//   Occupancy, Full     : vehicles inside, Occupancy == CAPACITY
module plate_gate_ctrl
  import plate_gate_ctrl_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 6,
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned OPEN_CYCLES = 3,
  parameter int unsigned OCC_W       = $clog2(CAPACITY + 1)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Req,
  input  logic [DIGIT_W*N_DIGITS-1:0] Plate,
  input  logic [2:0]                  Dia,
  input  logic                        Exit,
  output logic                        Busy,
  output logic                        Done,
  output logic                        MatrVal,
  output logic                        Granted,
  output logic [2:0]                  DenyCode,
  output logic                        Barreira,
  output logic [OCC_W-1:0]            Occupancy,
  output logic                        Full
);

  localparam int unsigned TMR_W = (OPEN_CYCLES < 2) ? 1 : $clog2(OPEN_CYCLES + 1);

  state_t                        state;
  logic [DIGIT_W*N_DIGITS-1:0]   plate_q;
  logic [2:0]                    dia_q;
  logic [TMR_W-1:0]              timer;
  logic                          fmt_valid;
  logic [DIGIT_W-1:0]            last_num;
  logic [2:0]                    deny;
  logic                          grant_now;
  logic                          dec;

  plate_format_chk #(.N_DIGITS(N_DIGITS)) u_chk (
    .plate    (plate_q),
    .valid    (fmt_valid),
    .last_num (last_num)
  );

  assign Full = (Occupancy == OCC_W'(CAPACITY));

  // Odd weekday admits odd last digit; weekend skips the parity rule.
  always_comb begin
    deny = DENY_NONE;
    if (!fmt_valid)                                      deny = DENY_PLATE;
    else if (dia_q == 3'd0)                              deny = DENY_DAY;
    else if (dia_q <= 3'd5 && dia_q[0] != last_num[0])   deny = DENY_RESTRICT;
    else if (Full)                                       deny = DENY_FULL;
  end

  assign grant_now = (state == ST_EVAL) && (deny == DENY_NONE);
  assign dec       = Exit && (Occupancy != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      MatrVal  <= 1'b0;
      Granted  <= 1'b0;
      DenyCode <= DENY_NONE;
      Barreira <= 1'b0;
      timer    <= '0;
      plate_q  <= '0;
      dia_q    <= '0;
    end else begin
      Done     <= 1'b0;
      MatrVal  <= 1'b0;
      Granted  <= 1'b0;
      DenyCode <= DENY_NONE;
      case (state)
        ST_IDLE: begin
          if (Req) begin
            plate_q <= Plate;
            dia_q   <= Dia;
            state   <= ST_EVAL;
            Busy    <= 1'b1;
          end
        end
        ST_EVAL: begin
          Done     <= 1'b1;
          MatrVal  <= fmt_valid;
          Granted  <= grant_now;
          DenyCode <= deny;
          if (grant_now) begin
            state    <= ST_OPEN;
            timer    <= TMR_W'(OPEN_CYCLES);
            Barreira <= 1'b1;
          end else begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        ST_OPEN: begin
          if (timer == TMR_W'(1)) begin
            state    <= ST_IDLE;
            Barreira <= 1'b0;
            Busy     <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          Busy     <= 1'b0;
          Barreira <= 1'b0;
        end
      endcase
    end
  end

  // Simultaneous grant and departure cancel out.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Occupancy <= '0;
    end else if (grant_now && !dec) begin
      Occupancy <= Occupancy + OCC_W'(1);
    end else if (!grant_now && dec) begin
      Occupancy <= Occupancy - OCC_W'(1);
    end
  end

endmodule
